// File: rtl/mtr_drv_if.sv
// Command/status bundle for the dual-channel motor PWM driver.
interface mtr_drv_if;
    logic signed [11:0] lft_spd;
    logic signed [11:0] rght_spd;
    logic               ovr_i;
    logic               flt_clr;
    logic               lft_PWM1;
    logic               lft_PWM2;
    logic               rght_PWM1;
    logic               rght_PWM2;
    logic               PWM_synch;
    logic               flt;

    modport master (
        output lft_spd, rght_spd, ovr_i, flt_clr,
        input  lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, flt
    );

    modport slave (
        input  lft_spd, rght_spd, ovr_i, flt_clr,
        output lft_PWM1, lft_PWM2, rght_PWM1, rght_PWM2, PWM_synch, flt
    );
endinterface

// File: rtl/mtr_drv.sv
// Two-channel H-bridge gate driver: 2048-cycle PWM with per-edge deadtime
// and a latched, synchronized overcurrent fault that blanks all gates.
module mtr_drv #(
    parameter logic [5:0] DEADTIME = 6'd32
) (
    input logic      clk,
    input logic      rst_n,
    mtr_drv_if.slave bus
);

    logic [10:0]        cnt;
    logic [10:0]        duty    [2];
    logic signed [11:0] spd     [2];
    logic [5:0]         dead    [2];
    logic [1:0]         sig_nxt;
    logic [1:0]         pwm_sig;
    logic [1:0]         chan_on;
    logic [1:0]         pwm1;
    logic [1:0]         pwm2;
    logic               synch_q;
    logic               ovr_s1;
    logic               ovr_s2;
    logic               flt_q;
    logic               clr_evt;

    // Offset-binary conversion: -2048..2047 maps onto 0..2047.
    function automatic logic [10:0] spd_to_duty(input logic signed [11:0] s);
        logic [12:0] sum;
        sum = {s[11], s} + 13'd2048;
        return 11'(sum >> 1);
    endfunction

    always_comb begin
        spd[0]  = bus.lft_spd;
        spd[1]  = bus.rght_spd;
        clr_evt = flt_q & bus.flt_clr & ~ovr_s2;
        sig_nxt = '0;
        chan_on = '0;
        for (int unsigned ch = 0; ch < 2; ch++) begin
            sig_nxt[ch] = (cnt < duty[ch]);
            chan_on[ch] = (dead[ch] == DEADTIME) & ~flt_q & ~ovr_s2;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= '0;
            synch_q <= 1'b0;
            duty[0] <= 11'd1024;
            duty[1] <= 11'd1024;
        end else begin
            cnt     <= cnt + 11'd1;
            synch_q <= (cnt == '0);
            if (cnt == '1) begin
                for (int unsigned ch = 0; ch < 2; ch++) begin
                    duty[ch] <= spd_to_duty(spd[ch]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovr_s1 <= 1'b0;
            ovr_s2 <= 1'b0;
            flt_q  <= 1'b0;
        end else begin
            ovr_s1 <= bus.ovr_i;
            ovr_s2 <= ovr_s1;
            if (ovr_s2) begin
                flt_q <= 1'b1;
            end else if (clr_evt) begin
                flt_q <= 1'b0;
            end
        end
    end

    // The dead counter is cleared by the same edge that moves pwm_sig, so the
    // gap after the old output drops is exactly DEADTIME cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_sig <= '0;
            pwm1    <= '0;
            pwm2    <= '0;
            for (int unsigned ch = 0; ch < 2; ch++) begin
                dead[ch] <= '0;
            end
        end else begin
            for (int unsigned ch = 0; ch < 2; ch++) begin
                pwm_sig[ch] <= sig_nxt[ch];
                if (clr_evt || (sig_nxt[ch] != pwm_sig[ch])) begin
                    dead[ch] <= '0;
                end else if (dead[ch] < DEADTIME) begin
                    dead[ch] <= dead[ch] + 6'd1;
                end
                pwm1[ch] <= chan_on[ch] & pwm_sig[ch];
                pwm2[ch] <= chan_on[ch] & ~pwm_sig[ch];
            end
        end
    end

    assign bus.lft_PWM1  = pwm1[0];
    assign bus.lft_PWM2  = pwm2[0];
    assign bus.rght_PWM1 = pwm1[1];
    assign bus.rght_PWM2 = pwm2[1];
    assign bus.PWM_synch = synch_q;
    assign bus.flt       = flt_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Scoreboard bench for mtr_drv: per-period gate high-time counts, fault
// events with latency windows, and deadtime before outputs resume.
module tb_mtr_drv;

    localparam logic [5:0] DT  = 6'd32;
    localparam int         DTI = 32;

    logic   clk   = 1'b0;
    logic   rst_n = 1'b1;
    longint cyc   = 0;

    mtr_drv_if bus ();

    mtr_drv #(.DEADTIME(DT)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        longint start;
        bit     chk;
        int     l1, l2, r1, r2;
    } per_t;

    typedef struct {
        bit     val;
        longint lo, hi;
    } flt_t;

    per_t per_q[$];
    flt_t flt_q[$];
    int   res_q[$];

    int total = 0;
    int bad   = 0;
    int tmo   = 0;
    bit done  = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    int     c_l1 = 0, c_l2 = 0, c_r1 = 0, c_r2 = 0;
    int     overlap    = 0;
    longint last_synch = -1;
    longint arm_cyc    = 0;
    bit     armed      = 1'b0;
    bit     prev_flt   = 1'b0;
    bit     prev_rst   = 1'b1;
    bit     final_done = 1'b0;

    always @(negedge clk) begin : monitor
        per_t p;
        flt_t f;
        logic any_on;
        any_on = bus.lft_PWM1 | bus.lft_PWM2 | bus.rght_PWM1 | bus.rght_PWM2;
        if (!rst_n) begin
            if (prev_rst)
                check("reset_outputs",
                      {bus.lft_PWM1, bus.lft_PWM2, bus.rght_PWM1, bus.rght_PWM2,
                       bus.PWM_synch, bus.flt}, 0);
            c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0;
            last_synch = -1;
            prev_flt   = 1'b0;
            armed      = 1'b0;
        end else begin
            if (!prev_rst) begin
                armed   = 1'b1;
                arm_cyc = cyc;
            end
            if ((bus.lft_PWM1 & bus.lft_PWM2) | (bus.rght_PWM1 & bus.rght_PWM2))
                overlap++;
            if (bus.PWM_synch) begin
                if (last_synch >= 0) check("synch_interval", cyc - last_synch, 2048);
                last_synch = cyc;
                if (per_q.size() > 0 && per_q[0].start < cyc) begin
                    p = per_q.pop_front();
                    if (p.chk) begin
                        check("lft_PWM1_high", c_l1, p.l1);
                        check("lft_PWM2_high", c_l2, p.l2);
                        check("rght_PWM1_high", c_r1, p.r1);
                        check("rght_PWM2_high", c_r2, p.r2);
                    end
                end
                c_l1 = 0; c_l2 = 0; c_r1 = 0; c_r2 = 0;
            end
            c_l1 += int'(bus.lft_PWM1);
            c_l2 += int'(bus.lft_PWM2);
            c_r1 += int'(bus.rght_PWM1);
            c_r2 += int'(bus.rght_PWM2);

            if (bus.flt != prev_flt) begin
                check("flt_event_expected", flt_q.size() > 0, 1);
                if (flt_q.size() > 0) begin
                    f = flt_q.pop_front();
                    check("flt_value", bus.flt, f.val);
                    check("flt_in_window", (cyc >= f.lo) && (cyc <= f.hi), 1);
                end
                if (bus.flt) begin
                    check("flt_gates_off", {bus.lft_PWM1, bus.lft_PWM2,
                                            bus.rght_PWM1, bus.rght_PWM2}, 0);
                    armed = 1'b0;
                end else begin
                    armed   = 1'b1;
                    arm_cyc = cyc;
                end
            end
            prev_flt = bus.flt;

            if (armed && any_on) begin
                armed = 1'b0;
                check("resume_expected", res_q.size(), 1);
                if (res_q.size() > 0) check("resume_delay", cyc - arm_cyc, res_q.pop_front());
            end
        end
        prev_rst = rst_n;

        if (done && !final_done) begin
            final_done = 1'b1;
            check("synch_wait_timeouts", tmo, 0);
            check("pwm_overlap_cycles", overlap, 0);
            check("period_q_left", per_q.size(), 0);
            check("flt_q_left", flt_q.size(), 0);
            check("resume_q_left", res_q.size(), 0);
        end
    end

    // ---------------- stimulus ----------------
    task automatic run(input int n, input bit chk, input int l1, input int l2,
                       input int r1, input int r2, input bit rnd);
        per_t p;
        int   w;
        for (int i = 0; i < n; i++) begin
            w = 0;
            do begin
                @(negedge clk);
                w++;
                if (rnd && (w % 97 == 0)) begin
                    bus.lft_spd  = 12'($urandom);
                    bus.rght_spd = 12'($urandom);
                end
            end while (!bus.PWM_synch && w < 2200);
            if (!bus.PWM_synch) begin
                tmo++;
                return;
            end
            p.start = cyc; p.chk = chk;
            p.l1 = l1; p.l2 = l2; p.r1 = r1; p.r2 = r2;
            per_q.push_back(p);
        end
    endtask

    task automatic reset_pulse();
        res_q.push_back(DTI + 2);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    initial begin : stim
        flt_t f;
        int   w;
        bus.lft_spd  = 12'sd0;
        bus.rght_spd = 12'sd0;
        bus.ovr_i    = 1'b0;
        bus.flt_clr  = 1'b0;
        #1 rst_n = 1'b0;
        reset_pulse();

        // both channels at zero speed
        run(1, 0, 0, 0, 0, 0, 0);
        run(2, 1, 992, 992, 992, 992, 0);

        // right +1000 -> duty 1524
        bus.rght_spd = 12'sd1000;
        run(2, 1, 992, 992, 1492, 492, 0);

        // left stepped at cnt==500: current period stays at duty 1024
        repeat (499) @(negedge clk);
        bus.lft_spd = 12'sd1000;
        run(2, 1, 1492, 492, 1492, 492, 0);

        // extremes: duty 0 and duty 2047
        bus.lft_spd  = -12'sd2048;
        bus.rght_spd = 12'sd2047;
        run(1, 0, 0, 0, 0, 0, 0);
        run(2, 1, 0, 2048, 2015, 0, 0);

        // fault handling inside one unchecked period
        bus.lft_spd  = 12'sd0;
        bus.rght_spd = 12'sd0;
        run(1, 0, 0, 0, 0, 0, 0);
        run(1, 0, 0, 0, 0, 0, 0);
        repeat (100) @(negedge clk);
        bus.ovr_i = 1'b1;
        f.val = 1'b1; f.lo = cyc + 1; f.hi = cyc + 3;
        flt_q.push_back(f);
        repeat (3) @(negedge clk);
        bus.ovr_i = 1'b0;
        repeat (5) @(negedge clk);
        bus.ovr_i = 1'b1;
        repeat (4) @(negedge clk);
        bus.flt_clr = 1'b1;
        @(negedge clk);
        bus.flt_clr = 1'b0;
        repeat (2) @(negedge clk);
        bus.ovr_i = 1'b0;
        repeat (5) @(negedge clk);
        bus.flt_clr = 1'b1;
        f.val = 1'b0; f.lo = cyc + 1; f.hi = cyc + 1;
        flt_q.push_back(f);
        res_q.push_back(DTI + 1);
        @(negedge clk);
        bus.flt_clr = 1'b0;
        run(2, 1, 992, 992, 992, 992, 0);

        // random speed commands, overlap watched throughout
        run(4, 0, 0, 0, 0, 0, 1);
        bus.lft_spd  = 12'sd0;
        bus.rght_spd = 12'sd0;
        run(1, 0, 0, 0, 0, 0, 0);
        run(1, 1, 992, 992, 992, 992, 0);

        // reset while a deadtime is in progress
        run(1, 0, 0, 0, 0, 0, 0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        reset_pulse();
        run(1, 0, 0, 0, 0, 0, 0);
        run(1, 1, 992, 992, 992, 992, 0);

        w = 0;
        while (per_q.size() > 0 && w < 2200) begin
            @(negedge clk);
            w++;
        end
        if (per_q.size() > 0) tmo++;
        done = 1'b1;
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
